// File: rtl/z80_bus_cycle_ctl_if.sv
// Bus bundle between the Z80 core/fabric side (master) and the bus-cycle
// controller (slave). Clock and reset stay outside as plain ports.
interface z80_bus_cycle_ctl_if;
    logic        clk_enable;
    logic        m1_n;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        rfsh_n;
    logic [15:0] A;
    logic        ext_wait_n;
    logic [7:0]  mem_di;
    logic [7:0]  io_di;
    logic [7:0]  im2_vec;
    logic        wait_n;
    logic [7:0]  cpu_di;
    logic        cyc_start;
    logic [2:0]  cyc_type;
    logic [15:0] cyc_addr;

    modport master (
        output clk_enable, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, A,
               ext_wait_n, mem_di, io_di, im2_vec,
        input  wait_n, cpu_di, cyc_start, cyc_type, cyc_addr
    );

    modport slave (
        input  clk_enable, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, A,
               ext_wait_n, mem_di, io_di, im2_vec,
        output wait_n, cpu_di, cyc_start, cyc_type, cyc_addr
    );
endinterface

// File: rtl/z80_bus_cycle_ctl.sv
// Z80 bus-cycle controller: classifies each CPU bus cycle on a clock-enable
// tick, latches its address, pulses a start strobe, inserts per-class wait
// states (stretched by an external wait request) and steers the CPU data bus.
module z80_bus_cycle_ctl #(
    parameter int unsigned MEM_WAITS  = 0,
    parameter int unsigned M1_WAITS   = 0,
    parameter int unsigned IO_WAITS   = 1,
    parameter int unsigned INTA_WAITS = 2,
    parameter logic [7:0]  FLOAT_BUS  = 8'hFF
) (
    input logic               clk,
    input logic               reset,
    z80_bus_cycle_ctl_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [2:0] CY_IDLE  = 3'd0;
    localparam logic [2:0] CY_FETCH = 3'd1;
    localparam logic [2:0] CY_MRD   = 3'd2;
    localparam logic [2:0] CY_MWR   = 3'd3;
    localparam logic [2:0] CY_IORD  = 3'd4;
    localparam logic [2:0] CY_IOWR  = 3'd5;
    localparam logic [2:0] CY_INTA  = 3'd6;
    localparam logic [2:0] CY_RFSH  = 3'd7;

    localparam logic [3:0] MEM_W  = 4'(MEM_WAITS);
    localparam logic [3:0] M1_W   = 4'(M1_WAITS);
    localparam logic [3:0] IO_W   = 4'(IO_WAITS);
    localparam logic [3:0] INTA_W = 4'(INTA_WAITS);

    logic [1:0]  state;
    logic [3:0]  wait_cnt;
    logic        cyc_start_q;
    logic [2:0]  cyc_type_q;
    logic [15:0] cyc_addr_q;
    logic        active;
    logic [2:0]  cls_type;
    logic [3:0]  cls_waits;

    assign active = (!bus.mreq_n && (!bus.rd_n || !bus.wr_n || !bus.rfsh_n)) || !bus.iorq_n;

    // Classify the current bus strobes into a cycle type and its wait count.
    always_comb begin
        cls_type  = CY_MWR;
        cls_waits = MEM_W;
        if (!bus.rfsh_n) begin
            cls_type  = CY_RFSH;
            cls_waits = '0;
        end else if (!bus.iorq_n && !bus.m1_n) begin
            cls_type  = CY_INTA;
            cls_waits = INTA_W;
        end else if (!bus.iorq_n) begin
            cls_type  = bus.rd_n ? CY_IOWR : CY_IORD;
            cls_waits = IO_W;
        end else if (!bus.m1_n) begin
            cls_type  = CY_FETCH;
            cls_waits = M1_W;
        end else if (!bus.rd_n) begin
            cls_type  = CY_MRD;
            cls_waits = MEM_W;
        end
    end

    // Cycle FSM, wait counter and start-of-cycle latches, advanced on ticks only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            cyc_start_q <= 1'b0;
            cyc_type_q  <= CY_IDLE;
            cyc_addr_q  <= '0;
        end else begin
            cyc_start_q <= 1'b0;
            if (bus.clk_enable) begin
                case (state)
                    ST_IDLE: begin
                        if (active) begin
                            state       <= ST_WAIT;
                            wait_cnt    <= cls_waits;
                            cyc_type_q  <= cls_type;
                            cyc_addr_q  <= bus.A;
                            cyc_start_q <= 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (wait_cnt != '0) begin
                            wait_cnt <= wait_cnt - 4'd1;
                        end else if (bus.ext_wait_n) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (!active) begin
                            state      <= ST_IDLE;
                            cyc_type_q <= CY_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // CPU data-in steering by latched cycle type and live read strobe.
    always_comb begin
        bus.cpu_di = FLOAT_BUS;
        if ((cyc_type_q == CY_FETCH || cyc_type_q == CY_MRD) && !bus.rd_n) begin
            bus.cpu_di = bus.mem_di;
        end else if (cyc_type_q == CY_IORD && !bus.rd_n) begin
            bus.cpu_di = bus.io_di;
        end else if (cyc_type_q == CY_INTA) begin
            bus.cpu_di = bus.im2_vec;
        end
    end

    assign bus.wait_n = !((state == ST_WAIT && wait_cnt != '0) ||
                          ((state == ST_WAIT || state == ST_RUN) && !bus.ext_wait_n));
    assign bus.cyc_start = cyc_start_q;
    assign bus.cyc_type  = cyc_type_q;
    assign bus.cyc_addr  = cyc_addr_q;

endmodule
